alu_arbiter: RTL

Shares the single 32-bit ALU between two requesters: requester 0 is the execute stage and requester 1 is the address/branch-target unit. Arbitration is round-robin, with one registered result slot and valid/ready handshakes on both sides. The block also owns the architectural condition-flag register (Z, N, C, V), which is updated only by granted operations that request it. It sits between the pipeline's operand-issue logic and writeback, wrapping the existing ALU instance.

---
 rtl/alu_arbiter_pkg.sv | 32 +++
 rtl/alu_arbiter_alu.sv | 52 +++++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared CPU definitions: ALU op codes, flag bit positions, and the
// request record the arbiter muxes onto the single ALU.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;
  localparam logic [OP_W-1:0] ALU_PASSB = 4'd10;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              setf;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 32-bit combinational ALU. C on SUB is "no borrow" (A >= B unsigned);
// logic, shift and compare ops report C=0, V=0.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   Op,
  output logic [DATA_W-1:0] Out,
  output logic              Z,
  output logic              N,
  output logic              C,
  output logic              V
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum = '0;
    Out = '0;
    C   = 1'b0;
    V   = 1'b0;
    case (Op)
      ALU_ADD: begin
        sum = {1'b0, A} + {1'b0, B};
        Out = sum[DATA_W-1:0];
        C   = sum[DATA_W];
        V   = (A[DATA_W-1] == B[DATA_W-1]) && (Out[DATA_W-1] != A[DATA_W-1]);
      end
      ALU_SUB: begin
        sum = {1'b0, A} + {1'b0, ~B} + {{DATA_W{1'b0}}, 1'b1};
        Out = sum[DATA_W-1:0];
        C   = sum[DATA_W];
        V   = (A[DATA_W-1] != B[DATA_W-1]) && (Out[DATA_W-1] != A[DATA_W-1]);
      end
      ALU_AND:   Out = A & B;
      ALU_OR:    Out = A | B;
      ALU_XOR:   Out = A ^ B;
      ALU_SLL:   Out = A << B[4:0];
      ALU_SRL:   Out = A >> B[4:0];
      ALU_SRA:   Out = $unsigned($signed(A) >>> B[4:0]);
      ALU_SLT:   Out = {{(DATA_W-1){1'b0}}, $signed(A) < $signed(B)};
      ALU_SLTU:  Out = {{(DATA_W-1){1'b0}}, A < B};
      ALU_PASSB: Out = B;
      default:   Out = '0;
    endcase
  end

  assign Z = (Out == '0);
  assign N = Out[DATA_W-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between execute (req0) and the address/branch
// unit (req1), with a single registered result slot and the ZNCV flag register.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_setf,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_setf,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_tag,
  output logic [DATA_W-1:0] resp_out,
  output logic [3:0]        resp_zncv,
  output logic [3:0]        flags
);

  alu_req_t req0, req1, win;
  logic slot_free, gnt0, gnt1, gnt;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_tag_q, resp_tag_d;
  logic [DATA_W-1:0] resp_out_q, resp_out_d;
  logic [3:0]        resp_zncv_q, resp_zncv_d;
  logic [3:0]        flags_q, flags_d;
  logic              prio_q, prio_d;

  logic [DATA_W-1:0] alu_out;
  logic              alu_z, alu_n, alu_c, alu_v;
  logic [3:0]        alu_zncv;

  assign req0 = '{op: req0_op, a: req0_a, b: req0_b, setf: req0_setf};
  assign req1 = '{op: req1_op, a: req1_a, b: req1_b, setf: req1_setf};

  // Grant depends only on valids, slot state and prio, never on operands.
  always_comb begin
    slot_free = !resp_valid_q || resp_ready;
    gnt0      = slot_free && req0_valid && (!req1_valid || !prio_q);
    gnt1      = slot_free && req1_valid && (!req0_valid ||  prio_q);
    gnt       = gnt0 || gnt1;
    win       = gnt1 ? req1 : req0;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  alu_arbiter_alu u_alu (
    .A   (win.a),
    .B   (win.b),
    .Op  (win.op),
    .Out (alu_out),
    .Z   (alu_z),
    .N   (alu_n),
    .C   (alu_c),
    .V   (alu_v)
  );

  always_comb begin
    alu_zncv         = '0;
    alu_zncv[FLAG_Z] = alu_z;
    alu_zncv[FLAG_N] = alu_n;
    alu_zncv[FLAG_C] = alu_c;
    alu_zncv[FLAG_V] = alu_v;
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_tag_d   = resp_tag_q;
    resp_out_d   = resp_out_q;
    resp_zncv_d  = resp_zncv_q;
    flags_d      = flags_q;
    prio_d       = prio_q;
    if (gnt) begin
      resp_valid_d = 1'b1;
      resp_tag_d   = gnt1;
      resp_out_d   = alu_out;
      resp_zncv_d  = alu_zncv;
      prio_d       = gnt0;
      if (win.setf) flags_d = alu_zncv;
    end else if (resp_ready) begin
      // Consumed with nothing new: data fields keep their stale values.
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_tag_q   <= 1'b0;
      resp_out_q   <= '0;
      resp_zncv_q  <= '0;
      flags_q      <= '0;
      prio_q       <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_out_q   <= resp_out_d;
      resp_zncv_q  <= resp_zncv_d;
      flags_q      <= flags_d;
      prio_q       <= prio_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_tag   = resp_tag_q;
  assign resp_out   = resp_out_q;
  assign resp_zncv  = resp_zncv_q;
  assign flags      = flags_q;

endmodule
